// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers the pixel/line position from hsync/vsync,
// measures line and frame timing, decides when the timing can be trusted
// (locked), and captures one probed pixel per frame while locked.
//
// Handshake: this block has no valid/ready flows. probe_valid_o is a
// one-cycle strobe that is high exactly when probe_rgb_o has just been
// loaded. h_err_o and v_err_o are one-cycle strobes, one per violation.
module vga_sync_receiver #(
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HPULSE  = 96,
    parameter int VPULSE  = 2
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [2:0]  red_i,
    input  logic [2:0]  green_i,
    input  logic [1:0]  blue_i,
    input  logic [9:0]  probe_x_i,
    input  logic [9:0]  probe_y_i,
    output logic        locked_o,
    output logic [10:0] line_len_o,
    output logic [10:0] frame_lines_o,
    output logic        h_err_o,
    output logic        v_err_o,
    output logic [7:0]  probe_rgb_o,
    output logic        probe_valid_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] HPIX_W  = 11'(HPIXELS);
    localparam logic [10:0] VLIN_W  = 11'(VLINES);
    localparam logic [10:0] HPUL_W  = 11'(HPULSE);
    localparam logic [10:0] VPUL_W  = 11'(VPULSE);
    localparam logic [10:0] WD_MAX  = 11'(2 * HPIXELS - 1);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    // Input sampling (s1) and edge-detect history (s2).
    logic        hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
    logic [7:0]  rgb_s1_q;

    // Position recovery and measurements.
    logic [10:0] cur_h_q, cur_h_d;
    logic [10:0] cur_v_q, cur_v_d;
    logic [10:0] vw_q, vw_d;
    logic [10:0] line_len_q, line_len_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic        h_seen_q, v_seen_q, v_pend_q, v_pend_d;
    logic        h_err_q, h_err_d, v_err_q, v_err_d;
    logic [7:0]  probe_rgb_q, probe_rgb_d;
    logic        probe_valid_q, probe_valid_d;

    // Lock FSM.
    state_t      state_q;
    logic [1:0]  frames_q;
    logic        clean_q;
    logic        locked_q;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        wd_hit, err_now;
    logic [10:0] h_plus1, v_plus1;

    assign hs_fall = hs_s2_q & ~hs_s1_q;
    assign hs_rise = ~hs_s2_q & hs_s1_q;
    assign vs_fall = vs_s2_q & ~vs_s1_q;
    assign vs_rise = ~vs_s2_q & vs_s1_q;
    assign h_plus1 = cur_h_q + 11'd1;
    assign v_plus1 = cur_v_q + 11'd1;
    // A line that runs to twice its nominal length means hsync is gone.
    assign wd_hit  = ~hs_fall && (cur_h_q == WD_MAX);
    assign err_now = h_err_d | v_err_d;

    // Next-state for position counters, measurements, errors and probe.
    always_comb begin
        cur_h_d       = cur_h_q;
        cur_v_d       = cur_v_q;
        v_pend_d      = v_pend_q;
        vw_d          = vw_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_err_d       = 1'b0;
        v_err_d       = 1'b0;
        probe_rgb_d   = probe_rgb_q;
        probe_valid_d = 1'b0;

        // Column of the pixel currently in s1; saturates instead of wrapping.
        if (hs_fall) begin
            cur_h_d = 11'd0;
        end else if (cur_h_q != WD_MAX) begin
            cur_h_d = h_plus1;
        end

        // A vsync fall anywhere in the line (up to and including its hsync
        // fall) makes that line line zero.
        if (hs_fall) begin
            if (vs_fall || v_pend_q) begin
                cur_v_d = 11'd0;
            end else if (cur_v_q != CNT_MAX) begin
                cur_v_d = v_plus1;
            end
            v_pend_d = 1'b0;
        end else if (vs_fall) begin
            v_pend_d = 1'b1;
        end

        // Vsync low width counted as line starts seen while vsync is low.
        if (vs_fall) begin
            vw_d = hs_fall ? 11'd1 : 11'd0;
        end else if (hs_fall && !vs_s1_q && (vw_q != CNT_MAX)) begin
            vw_d = vw_q + 11'd1;
        end

        // Nothing is measured until a starting edge has been seen.
        if (hs_fall && h_seen_q) begin
            line_len_d = h_plus1;
            if (h_plus1 != HPIX_W) h_err_d = 1'b1;
        end
        if (hs_rise && h_seen_q && (h_plus1 != HPUL_W)) h_err_d = 1'b1;

        if (vs_fall && v_seen_q) begin
            frame_lines_d = v_plus1;
            if (v_plus1 != VLIN_W) v_err_d = 1'b1;
        end
        if (vs_rise && v_seen_q && (vw_q != VPUL_W)) v_err_d = 1'b1;

        // Probe compares against the position of the s1 pixel.
        if ((state_q == LOCKED) && (cur_h_d < HPIX_W) && (cur_v_d < VLIN_W) &&
            (cur_h_d == {1'b0, probe_x_i}) && (cur_v_d == {1'b0, probe_y_i})) begin
            probe_rgb_d   = rgb_s1_q;
            probe_valid_d = 1'b1;
        end
    end

    // Input registers, counters, measurements and registered outputs.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            hs_s2_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            rgb_s1_q      <= 8'd0;
            cur_h_q       <= 11'd0;
            cur_v_q       <= 11'd0;
            vw_q          <= 11'd0;
            line_len_q    <= 11'd0;
            frame_lines_q <= 11'd0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            v_pend_q      <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            probe_rgb_q   <= 8'd0;
            probe_valid_q <= 1'b0;
        end else begin
            hs_s1_q       <= hsync_i;
            vs_s1_q       <= vsync_i;
            hs_s2_q       <= hs_s1_q;
            vs_s2_q       <= vs_s1_q;
            rgb_s1_q      <= {red_i, green_i, blue_i};
            cur_h_q       <= cur_h_d;
            cur_v_q       <= cur_v_d;
            vw_q          <= vw_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            h_seen_q      <= h_seen_q | hs_fall;
            v_seen_q      <= v_seen_q | vs_fall;
            v_pend_q      <= v_pend_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            probe_rgb_q   <= probe_rgb_d;
            probe_valid_q <= probe_valid_d;
        end
    end

    // Lock FSM: two clean complete frames in TRACK give LOCKED; any error
    // drops back to TRACK; losing hsync drops all the way to SEARCH.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            frames_q <= 2'd0;
            clean_q  <= 1'b0;
            locked_q <= 1'b0;
        end else if (wd_hit) begin
            state_q  <= SEARCH;
            frames_q <= 2'd0;
            clean_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q  <= TRACK;
                        frames_q <= 2'd0;
                        clean_q  <= 1'b1;
                    end
                end
                TRACK: begin
                    if (vs_fall) begin
                        clean_q <= 1'b1;
                        if (clean_q && !err_now) begin
                            if (frames_q == 2'd1) begin
                                state_q  <= LOCKED;
                                frames_q <= 2'd0;
                                locked_q <= 1'b1;
                            end else begin
                                frames_q <= frames_q + 2'd1;
                            end
                        end else begin
                            frames_q <= 2'd0;
                        end
                    end else if (err_now) begin
                        frames_q <= 2'd0;
                        clean_q  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (err_now) begin
                        state_q  <= TRACK;
                        frames_q <= 2'd0;
                        clean_q  <= vs_fall;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    frames_q <= 2'd0;
                    clean_q  <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked_o      = locked_q;
    assign line_len_o    = line_len_q;
    assign frame_lines_o = frame_lines_q;
    assign h_err_o       = h_err_q;
    assign v_err_o       = v_err_q;
    assign probe_rgb_o   = probe_rgb_q;
    assign probe_valid_o = probe_valid_q;
    assign state_o       = state_q;

endmodule
